// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg : shared types and constants for the instruction fetch stage
// Revision: 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam int unsigned     INSTR_BYTES      = 4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : 2-entry shift FIFO of {instr, pc}; head holds after draining
// Revision: 1.0
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t r_e0;
    fetch_entry_t r_e1;
    logic [1:0]   r_count;

    // Entry 0 is always the head, so it keeps the last delivered word when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
        end else if (clear) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (push) begin
                        r_e0    <= push_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        r_e0 <= push_data;
                    end else if (push) begin
                        r_e1    <= push_data;
                        r_count <= 2'd2;
                    end else if (pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        r_e0 <= r_e1;
                        if (push) begin
                            r_e1 <= push_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head  = r_e0;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC, ROM request credit logic, redirect/flush and fault control
// Revision: 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  read_instr,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  fetch_fault
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_infl_v;
    logic [DATA_WIDTH-1:0] r_infl_pc;
    logic                  r_fault;

    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occ;
    logic [2:0]            w_limit;
    logic [1:0]            w_count;
    fetch_entry_t          w_push_data;
    fetch_entry_t          w_head;

    // Buffered plus in-flight words must stay within the two FIFO slots.
    assign w_pop   = out_valid & out_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_infl_v};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_issue = !rst && !redirect_valid && !r_fault && (w_occ < w_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_infl_v  <= 1'b0;
            r_infl_pc <= '0;
            r_fault   <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_infl_v <= 1'b0;
            r_fault  <= (redirect_pc[1:0] != 2'b00);
        end else begin
            r_infl_v <= w_issue;
            if (w_issue) begin
                r_infl_pc <= r_pc;
                r_pc      <= r_pc + DATA_WIDTH'(INSTR_BYTES);
            end
        end
    end

    assign w_push_data.instr = imem_data;
    assign w_push_data.pc    = r_infl_pc;

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (r_infl_v),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    assign read_instr  = w_issue;
    assign imem_addr   = r_pc;
    assign out_valid   = (w_count != 2'd0);
    assign out_instr   = w_head.instr;
    assign out_pc      = w_head.pc;
    assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : scoreboard bench for fetch_unit with a 1-cycle ROM model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        read_instr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] rom_q  = '0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .read_instr     (read_instr),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + ((a - RST_PC) >> 2);
    endfunction

    always @(posedge clk) if (read_instr) rom_q <= rom_word(imem_addr);
    assign imem_data = rom_q;

    always @(posedge rst) begin
        sb.delete();
        exp_pc = RST_PC;
    end

    // Scoreboard: requests push expectations, handshakes pop and compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got pc %h instr %h, expected no output", out_pc, out_instr);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_pc !== mon_e.pc || out_instr !== mon_e.instr)
                        $display("FAIL sb_data: got pc %h instr %h, expected pc %h instr %h", out_pc, out_instr, mon_e.pc, mon_e.instr);
                    else n_pass++;
                end
            end
            if (redirect_valid) begin
                n_checks++; if (read_instr !== 1'b0) $display("FAIL sb_redirect_issue: got read_instr %b expected 0", read_instr); else n_pass++;
                sb.delete();
                exp_pc = redirect_pc;
            end else if (read_instr) begin
                n_checks++; if (imem_addr !== exp_pc) $display("FAIL sb_addr: got %h expected %h", imem_addr, exp_pc); else n_pass++;
                sb.push_back(exp_t'{instr: rom_word(imem_addr), pc: imem_addr});
                exp_pc = exp_pc + 32'd4;
                n_checks++; if (sb.size() > 2) $display("FAIL sb_outstanding: got %0d outstanding expected <= 2", sb.size()); else n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h expected 0", out_instr); else n_pass++;
        n_checks++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc: got %h expected 0", out_pc); else n_pass++;
        n_checks++; if (read_instr !== 1'b0) $display("FAIL reset_read_instr: got %b expected 0", read_instr); else n_pass++;
        n_checks++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fetch_fault); else n_pass++;
        n_checks++; if (imem_addr !== RST_PC) $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (read_instr !== 1'b1) $display("FAIL first_issue: got %b expected 1", read_instr); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL first_c0_valid: got %b expected 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL first_c1_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (imem_addr !== RST_PC + 32'd4) $display("FAIL first_c1_addr: got %h expected %h", imem_addr, RST_PC + 32'd4); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL first_c2_valid: got %b expected 1", out_valid); else n_pass++;
        n_checks++; if (out_pc !== RST_PC || out_instr !== 32'h1000_0000) $display("FAIL first_c2_data: got pc %h instr %h expected pc %h instr 10000000", out_pc, out_instr, RST_PC); else n_pass++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || read_instr !== 1'b1) $display("FAIL stream_rate: got valid %b read %b expected 1 1", out_valid, read_instr); else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        held_pc = out_pc;
        n_checks++; if (read_instr !== 1'b0) $display("FAIL stall_first_read: got %b expected 0", read_instr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (read_instr !== 1'b0 || out_valid !== 1'b1 || out_pc !== held_pc)
                $display("FAIL stall_hold: got read %b valid %b pc %h expected 0 1 %h", read_instr, out_valid, out_pc, held_pc); else n_pass++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (read_instr !== 1'b1) $display("FAIL stall_release_read: got %b expected 1", read_instr); else n_pass++;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_redirect(input logic [31:0] target, input bit stall_first);
        if (stall_first) begin
            @(posedge clk); #1 out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) $display("FAIL redir_full_valid: got %b expected 1", out_valid); else n_pass++;
        end
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = target;
        @(negedge clk);
        n_checks++; if (read_instr !== 1'b0) $display("FAIL redir_r_read: got %b expected 0", read_instr); else n_pass++;
        @(posedge clk); #1 redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (read_instr !== 1'b1 || imem_addr !== target) $display("FAIL redir_r1_req: got read %b addr %h expected 1 %h", read_instr, imem_addr, target); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || fetch_fault !== 1'b0) $display("FAIL redir_r1_flush: got valid %b fault %b expected 0 0", out_valid, fetch_fault); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL redir_r2_valid: got %b expected 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== target || out_instr !== rom_word(target))
            $display("FAIL redir_r3_data: got valid %b pc %h instr %h expected 1 %h %h", out_valid, out_pc, out_instr, target, rom_word(target)); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fault();
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0100_0042;
        @(posedge clk); #1 redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (fetch_fault !== 1'b1 || read_instr !== 1'b0 || out_valid !== 1'b0)
                $display("FAIL fault_hold: got fault %b read %b valid %b expected 1 0 0", fetch_fault, read_instr, out_valid); else n_pass++;
        end
        test_redirect(32'h0100_0080, 1'b0);
    endtask

    task automatic test_wrap();
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h expected fffffffc", imem_addr); else n_pass++;
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'h0 || read_instr !== 1'b1) $display("FAIL wrap_addr1: got addr %h read %b expected 0 1", imem_addr, read_instr); else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || read_instr !== 1'b0 || fetch_fault !== 1'b0)
            $display("FAIL mid_reset_ctrl: got valid %b read %b fault %b expected 0 0 0", out_valid, read_instr, fetch_fault); else n_pass++;
        n_checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || imem_addr !== RST_PC)
            $display("FAIL mid_reset_data: got pc %h instr %h addr %h expected 0 0 %h", out_pc, out_instr, imem_addr, RST_PC); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (read_instr !== 1'b1 || imem_addr !== RST_PC) $display("FAIL mid_restart: got read %b addr %h expected 1 %h", read_instr, imem_addr, RST_PC); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_c1_valid: got %b expected 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC) $display("FAIL mid_c2_data: got valid %b pc %h expected 1 %h", out_valid, out_pc, RST_PC); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect(32'h0100_0040, 1'b1);
        test_redirect(32'h0100_0040, 1'b0);
        test_fault();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
